// File: rtl/vga_box_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : vga_box_motion_ctrl
// Brief   : Once-per-frame bouncing-box scheduler with a shadowed config port.
// Revision: 1.0
// ============================================================================
module vga_box_motion_ctrl #(
    parameter int H_MIN     = 144,
    parameter int H_MAX     = 783,
    parameter int V_MIN     = 31,
    parameter int V_MAX     = 510,
    parameter int INIT_X    = 384,
    parameter int INIT_Y    = 391,
    parameter int INIT_W    = 160,
    parameter int INIT_H    = 120,
    parameter int INIT_STEP = 1
) (
    input  logic       clk,
    input  logic       rst_n,        // active-high synchronous reset despite the name
    input  logic       frame_start,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_addr,
    input  logic [9:0] cfg_data,
    output logic [9:0] left_pos,
    output logic [9:0] right_pos,
    output logic [9:0] up_pos,
    output logic [9:0] down_pos,
    output logic [7:0] box_rgb,
    output logic       busy
);

    localparam logic [9:0] c_H_MIN   = 10'(H_MIN);
    localparam logic [9:0] c_H_MAX   = 10'(H_MAX);
    localparam logic [9:0] c_V_MIN   = 10'(V_MIN);
    localparam logic [9:0] c_V_MAX   = 10'(V_MAX);
    localparam logic [9:0] c_H_SPAN  = 10'(H_MAX - H_MIN + 1);
    localparam logic [9:0] c_V_SPAN  = 10'(V_MAX - V_MIN + 1);
    localparam logic [9:0] c_H_SUM   = 10'(H_MIN + H_MAX + 1);
    localparam logic [9:0] c_V_SUM   = 10'(V_MIN + V_MAX + 1);
    localparam logic [9:0] c_INIT_X  = 10'(INIT_X);
    localparam logic [9:0] c_INIT_Y  = 10'(INIT_Y);
    localparam logic [9:0] c_INIT_W  = 10'(INIT_W);
    localparam logic [9:0] c_INIT_H  = 10'(INIT_H);
    localparam logic [9:0] c_INIT_R  = 10'(INIT_X + INIT_W - 1);
    localparam logic [9:0] c_INIT_D  = 10'(INIT_Y + INIT_H - 1);
    localparam logic [3:0] c_INIT_ST = 4'(INIT_STEP);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_MOVE   = 2'd2
    } state_t;

    function automatic logic [7:0] f_palette(input logic [1:0] idx);
        case (idx)
            2'd0:    f_palette = 8'hE0;
            2'd1:    f_palette = 8'h1C;
            2'd2:    f_palette = 8'h03;
            default: f_palette = 8'hFC;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [9:0] left_q, left_d, right_q, right_d;
    logic [9:0] up_q, up_d, down_q, down_d;
    logic       dir_h_q, dir_h_d;            // 1 = moving right
    logic       dir_v_q, dir_v_d;            // 1 = moving down
    logic [9:0] box_w_q, box_w_d, box_h_q, box_h_d;
    logic [3:0] step_q, step_d;
    logic       pause_q, pause_d;
    logic [9:0] sh_w_q, sh_w_d, sh_h_q, sh_h_d;
    logic [3:0] sh_step_q, sh_step_d;
    logic       sh_pause_q, sh_pause_d;
    logic       sh_recenter_q, sh_recenter_d;
    logic [1:0] color_idx_q, color_idx_d;
    logic [7:0] box_rgb_q, box_rgb_d;
    logic       busy_q, busy_d;
    logic       cfg_ready_q, cfg_ready_d;

    // Write-time saturation keeps the shadow copy always legal.
    logic       w_cfg_fire;
    logic [9:0] w_sat_w, w_sat_h;

    assign w_cfg_fire = cfg_valid && cfg_ready_q;
    assign w_sat_w    = (cfg_data == 10'd0) ? 10'd1 :
                        (cfg_data > c_H_SPAN) ? c_H_SPAN : cfg_data;
    assign w_sat_h    = (cfg_data == 10'd0) ? 10'd1 :
                        (cfg_data > c_V_SPAN) ? c_V_SPAN : cfg_data;

    // Commit-time placement: pull the box back inside, or recenter it.
    logic       w_cm_h_over, w_cm_v_over;
    logic [9:0] w_cm_left, w_cm_up;

    assign w_cm_h_over = ({1'b0, left_q} + {1'b0, sh_w_q} - 11'd1) > {1'b0, c_H_MAX};
    assign w_cm_v_over = ({1'b0, up_q} + {1'b0, sh_h_q} - 11'd1) > {1'b0, c_V_MAX};
    assign w_cm_left   = sh_recenter_q ? ((c_H_SUM - sh_w_q) >> 1) :
                         w_cm_h_over   ? (c_H_MAX - sh_w_q + 10'd1) : left_q;
    assign w_cm_up     = sh_recenter_q ? ((c_V_SUM - sh_h_q) >> 1) :
                         w_cm_v_over   ? (c_V_MAX - sh_h_q + 10'd1) : up_q;

    // Bounce tests are done one bit wider so edge + step cannot wrap.
    logic w_hit_right, w_hit_left, w_hit_down, w_hit_up;

    assign w_hit_right = ({1'b0, right_q} + {7'd0, step_q}) >= {1'b0, c_H_MAX};
    assign w_hit_left  = {1'b0, left_q} <= ({1'b0, c_H_MIN} + {7'd0, step_q});
    assign w_hit_down  = ({1'b0, down_q} + {7'd0, step_q}) >= {1'b0, c_V_MAX};
    assign w_hit_up    = {1'b0, up_q} <= ({1'b0, c_V_MIN} + {7'd0, step_q});

    always_comb begin
        state_d       = state_q;
        left_d        = left_q;
        right_d       = right_q;
        up_d          = up_q;
        down_d        = down_q;
        dir_h_d       = dir_h_q;
        dir_v_d       = dir_v_q;
        box_w_d       = box_w_q;
        box_h_d       = box_h_q;
        step_d        = step_q;
        pause_d       = pause_q;
        sh_w_d        = sh_w_q;
        sh_h_d        = sh_h_q;
        sh_step_d     = sh_step_q;
        sh_pause_d    = sh_pause_q;
        sh_recenter_d = sh_recenter_q;
        color_idx_d   = color_idx_q;
        box_rgb_d     = box_rgb_q;

        if (w_cfg_fire) begin
            case (cfg_addr)
                2'd0: sh_w_d = w_sat_w;
                2'd1: sh_h_d = w_sat_h;
                2'd2: sh_step_d = cfg_data[3:0];
                default: begin
                    sh_pause_d    = cfg_data[0];
                    sh_recenter_d = cfg_data[1];
                end
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                box_w_d       = sh_w_q;
                box_h_d       = sh_h_q;
                step_d        = sh_step_q;
                pause_d       = sh_pause_q;
                sh_recenter_d = 1'b0;
                left_d        = w_cm_left;
                right_d       = w_cm_left + sh_w_q - 10'd1;
                up_d          = w_cm_up;
                down_d        = w_cm_up + sh_h_q - 10'd1;
                state_d       = ST_MOVE;
            end
            ST_MOVE: begin
                if (!pause_q) begin
                    if (dir_h_q) begin
                        if (w_hit_right) begin
                            left_d  = c_H_MAX - box_w_q + 10'd1;
                            right_d = c_H_MAX;
                            dir_h_d = 1'b0;
                        end else begin
                            left_d  = left_q + {6'd0, step_q};
                            right_d = right_q + {6'd0, step_q};
                        end
                    end else begin
                        if (w_hit_left) begin
                            left_d  = c_H_MIN;
                            right_d = c_H_MIN + box_w_q - 10'd1;
                            dir_h_d = 1'b1;
                        end else begin
                            left_d  = left_q - {6'd0, step_q};
                            right_d = right_q - {6'd0, step_q};
                        end
                    end

                    if (dir_v_q) begin
                        if (w_hit_down) begin
                            up_d    = c_V_MAX - box_h_q + 10'd1;
                            down_d  = c_V_MAX;
                            dir_v_d = 1'b0;
                        end else begin
                            up_d    = up_q + {6'd0, step_q};
                            down_d  = down_q + {6'd0, step_q};
                        end
                    end else begin
                        if (w_hit_up) begin
                            up_d    = c_V_MIN;
                            down_d  = c_V_MIN + box_h_q - 10'd1;
                            dir_v_d = 1'b1;
                        end else begin
                            up_d    = up_q - {6'd0, step_q};
                            down_d  = down_q - {6'd0, step_q};
                        end
                    end

                    color_idx_d = color_idx_q + 2'd1;
                    box_rgb_d   = f_palette(color_idx_q + 2'd1);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        cfg_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q       <= ST_IDLE;
            left_q        <= c_INIT_X;
            right_q       <= c_INIT_R;
            up_q          <= c_INIT_Y;
            down_q        <= c_INIT_D;
            dir_h_q       <= 1'b1;
            dir_v_q       <= 1'b0;
            box_w_q       <= c_INIT_W;
            box_h_q       <= c_INIT_H;
            step_q        <= c_INIT_ST;
            pause_q       <= 1'b0;
            sh_w_q        <= c_INIT_W;
            sh_h_q        <= c_INIT_H;
            sh_step_q     <= c_INIT_ST;
            sh_pause_q    <= 1'b0;
            sh_recenter_q <= 1'b0;
            color_idx_q   <= 2'd0;
            box_rgb_q     <= 8'hE0;
            busy_q        <= 1'b0;
            cfg_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            left_q        <= left_d;
            right_q       <= right_d;
            up_q          <= up_d;
            down_q        <= down_d;
            dir_h_q       <= dir_h_d;
            dir_v_q       <= dir_v_d;
            box_w_q       <= box_w_d;
            box_h_q       <= box_h_d;
            step_q        <= step_d;
            pause_q       <= pause_d;
            sh_w_q        <= sh_w_d;
            sh_h_q        <= sh_h_d;
            sh_step_q     <= sh_step_d;
            sh_pause_q    <= sh_pause_d;
            sh_recenter_q <= sh_recenter_d;
            color_idx_q   <= color_idx_d;
            box_rgb_q     <= box_rgb_d;
            busy_q        <= busy_d;
            cfg_ready_q   <= cfg_ready_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign busy      = busy_q;
    assign left_pos  = left_q;
    assign right_pos = right_q;
    assign up_pos    = up_q;
    assign down_pos  = down_q;
    assign box_rgb   = box_rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_box_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_box_motion_ctrl
// Brief   : Directed self-checking bench for vga_box_motion_ctrl.
// Revision: 1.0
// ============================================================================
module tb_vga_box_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_addr;
    logic [9:0] cfg_data;
    logic [9:0] left_pos, right_pos, up_pos, down_pos;
    logic [7:0] box_rgb;
    logic       busy;

    int pass_cnt = 0;
    int total    = 0;

    vga_box_motion_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .left_pos    (left_pos),
        .right_pos   (right_pos),
        .up_pos      (up_pos),
        .down_pos    (down_pos),
        .box_rgb     (box_rgb),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    task automatic check_box(input string tag, input int l, input int r, input int u,
                             input int d, input logic [7:0] rgb);
        check({tag, " left"},  32'(left_pos),  32'(l));
        check({tag, " right"}, 32'(right_pos), 32'(r));
        check({tag, " up"},    32'(up_pos),    32'(u));
        check({tag, " down"},  32'(down_pos),  32'(d));
        check({tag, " rgb"},   32'(box_rgb),   32'(rgb));
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [9:0] data);
        cfg_valid = 1'b1;
        cfg_addr  = addr;
        cfg_data  = data;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst_n       = 1'b1;
        frame_start = 1'b0;
        cfg_valid   = 1'b0;
        cfg_addr    = 2'd0;
        cfg_data    = 10'd0;
        repeat (3) step();
        check("rst ready", 32'(cfg_ready), 32'd0);
        check("rst busy",  32'(busy),      32'd0);

        // Release reset
        rst_n = 1'b0;
        step();
        check_box("init", 384, 543, 391, 510, 8'hE0);
        check("init ready", 32'(cfg_ready), 32'd1);
        check("init busy",  32'(busy),      32'd0);

        // One frame with default config, latency check
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("f1 busy T+1", 32'(busy), 32'd1);
        check("f1 hold T+1", 32'(left_pos), 32'd384);
        step();
        check("f1 busy T+2", 32'(busy), 32'd1);
        check("f1 ready T+2", 32'(cfg_ready), 32'd0);
        step();
        check("f1 busy T+3", 32'(busy), 32'd0);
        check_box("f1", 385, 544, 390, 509, 8'h1C);

        // Step 7, run into the right wall
        cfg_write(2'd2, 10'd7);
        repeat (35) do_frame();
        check("s7 left",  32'(left_pos),  32'd624);
        check("s7 right", 32'(right_pos), 32'd783);
        do_frame();
        check_box("s7 bounce", 617, 776, 138, 257, 8'h1C);

        // Oversized width: shadowed until the frame, then saturated and clamped
        cfg_write(2'd0, 10'd700);
        check("w700 hold left",  32'(left_pos),  32'd617);
        check("w700 hold right", 32'(right_pos), 32'd776);
        do_frame();
        check_box("w700", 144, 783, 131, 250, 8'h03);

        // Pause written alongside frame_start, second pulse during COMMIT ignored
        cfg_valid   = 1'b1;
        cfg_addr    = 2'd3;
        cfg_data    = 10'd1;
        frame_start = 1'b1;
        step();
        cfg_valid   = 1'b0;
        check("pause busy T+1", 32'(busy), 32'd1);
        step();
        frame_start = 1'b0;
        check("pause busy T+2", 32'(busy), 32'd1);
        step();
        check("pause busy T+3", 32'(busy), 32'd0);
        check_box("pause", 144, 783, 131, 250, 8'h03);
        step();
        check("pause busy T+4", 32'(busy), 32'd0);
        step();
        check("pause busy T+5", 32'(busy), 32'd0);

        // Reset asserted during MOVE
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        check("pre-rst busy", 32'(busy), 32'd1);
        rst_n = 1'b1;
        step();
        check_box("mid rst", 384, 543, 391, 510, 8'hE0);
        check("mid rst busy",  32'(busy),      32'd0);
        check("mid rst ready", 32'(cfg_ready), 32'd0);
        rst_n = 1'b0;
        step();
        check("post rst ready", 32'(cfg_ready), 32'd1);

        // Height 0 saturates to 1, recenter applied once then self-clears
        cfg_write(2'd1, 10'd0);
        cfg_write(2'd3, 10'd2);
        do_frame();
        check_box("recenter", 385, 544, 269, 269, 8'h1C);
        do_frame();
        check_box("after rc", 386, 545, 268, 268, 8'h03);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
`default_nettype wire
